// File: rtl/vga_pkg.sv
// Shared VGA types: screen-select state and game-flow defaults used by the
// screen-selection stage and the game flow controller.
package vga_pkg;

    typedef enum logic [1:0] {
        START    = 2'd0,
        GAME     = 2'd1,
        PLAYER_1 = 2'd2,
        PLAYER_2 = 2'd3
    } state;

    localparam int unsigned WIN_POINTS_DEF  = 10;
    localparam int unsigned HOLD_CYCLES_DEF = 325_000_000;
    localparam int unsigned HOLD_CNT_W_DEF  = 29;
    localparam logic [3:0]  TALLY_MAX       = 4'hF;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == TALLY_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator; the delayed sample resets to RST_VAL so a
// level held high through reset can be masked.
module edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig;
        end
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: START -> GAME -> winner screen -> START, with a
// one-cycle game-clear strobe and saturating per-player match tallies.
module game_state_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned WIN_POINTS  = WIN_POINTS_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned CNT_W       = HOLD_CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic [3:0] points_p1,
    input  logic [3:0] points_p2,
    output state       screen,
    output logic       game_clr,
    output logic       in_game,
    output logic [3:0] wins_p1,
    output logic [3:0] wins_p2
);

    localparam logic [3:0]       WIN_THR   = 4'(WIN_POINTS);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             start_edge;
    state             state_q, state_d;
    logic             game_clr_q, game_clr_d;
    logic             in_game_q, in_game_d;
    logic [3:0]       wins_p1_q, wins_p1_d;
    logic [3:0]       wins_p2_q, wins_p2_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // Delayed sample resets high so a button held through reset is not a press.
    edge_detect #(
        .RST_VAL (1'b1)
    ) u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .sig   (start_btn),
        .pulse (start_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= START;
            game_clr_q <= 1'b0;
            in_game_q  <= 1'b0;
            wins_p1_q  <= '0;
            wins_p2_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            game_clr_q <= game_clr_d;
            in_game_q  <= in_game_d;
            wins_p1_q  <= wins_p1_d;
            wins_p2_q  <= wins_p2_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        game_clr_d = 1'b0;
        wins_p1_d  = wins_p1_q;
        wins_p2_d  = wins_p2_q;
        hold_cnt_d = '0;

        unique case (state_q)
            START: begin
                if (start_edge) begin
                    state_d    = GAME;
                    game_clr_d = 1'b1;
                end
            end
            GAME: begin
                // Player 1 wins a tie on the same cycle.
                if (points_p1 >= WIN_THR) begin
                    state_d   = PLAYER_1;
                    wins_p1_d = sat_inc4(wins_p1_q);
                end else if (points_p2 >= WIN_THR) begin
                    state_d   = PLAYER_2;
                    wins_p2_d = sat_inc4(wins_p2_q);
                end
            end
            PLAYER_1, PLAYER_2: begin
                if (start_edge || (hold_cnt_q == HOLD_LAST)) begin
                    state_d = START;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = START;
            end
        endcase

        in_game_d = (state_d == GAME);
    end

    assign screen   = state_q;
    assign game_clr = game_clr_q;
    assign in_game  = in_game_q;
    assign wins_p1  = wins_p1_q;
    assign wins_p2  = wins_p2_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with WIN_POINTS=3, HOLD_CYCLES=8.
module tb_game_state_ctrl;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic [3:0] points_p1;
    logic [3:0] points_p2;
    state       screen;
    logic       game_clr;
    logic       in_game;
    logic [3:0] wins_p1;
    logic [3:0] wins_p2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_p2;

    game_state_ctrl #(
        .WIN_POINTS  (3),
        .HOLD_CYCLES (8),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .points_p1 (points_p1),
        .points_p2 (points_p2),
        .screen    (screen),
        .game_clr  (game_clr),
        .in_game   (in_game),
        .wins_p1   (wins_p1),
        .wins_p2   (wins_p2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start_btn = 1'b1;
        points_p1 = 4'd0;
        points_p2 = 4'd0;

        // 1: button held through reset must not start a game
        tick();
        check("rst_screen", 32'(screen), 32'(START));
        check("rst_clr", 32'(game_clr), 0);
        check("rst_wins1", 32'(wins_p1), 0);
        check("rst_wins2", 32'(wins_p2), 0);
        tick();
        rst = 1'b0;
        tick();
        check("held_screen", 32'(screen), 32'(START));
        check("held_clr", 32'(game_clr), 0);
        start_btn = 1'b0;
        tick();
        check("rel_screen", 32'(screen), 32'(START));
        press();
        check("start_screen", 32'(screen), 32'(GAME));
        check("start_clr", 32'(game_clr), 1);
        check("start_ingame", 32'(in_game), 1);
        tick();
        check("clr_once", 32'(game_clr), 0);
        check("ingame_hold", 32'(in_game), 1);

        // 2: ramp p1 to threshold, then timed return to START
        points_p2 = 4'd1;
        for (int p = 0; p < 3; p++) begin
            points_p1 = 4'(p);
            tick();
            check("ramp_game", 32'(screen), 32'(GAME));
        end
        points_p1 = 4'd3;
        tick();
        check("p1_win_screen", 32'(screen), 32'(PLAYER_1));
        check("p1_win_tally", 32'(wins_p1), 1);
        check("p1_win_ingame", 32'(in_game), 0);
        for (int i = 0; i < 7; i++) tick();
        check("hold_last", 32'(screen), 32'(PLAYER_1));
        check("hold_no_reinc", 32'(wins_p1), 1);
        tick();
        check("hold_done", 32'(screen), 32'(START));
        check("hold_tally", 32'(wins_p1), 1);
        points_p1 = 4'd0;
        points_p2 = 4'd0;

        // 3: simultaneous threshold, player 1 priority
        press();
        check("tie_game", 32'(screen), 32'(GAME));
        points_p1 = 4'd3;
        points_p2 = 4'd3;
        tick();
        check("tie_screen", 32'(screen), 32'(PLAYER_1));
        check("tie_p1", 32'(wins_p1), 2);
        check("tie_p2", 32'(wins_p2), 0);
        points_p1 = 4'd0;
        points_p2 = 4'd0;
        press();
        check("skip1_screen", 32'(screen), 32'(START));

        // 4: skip from PLAYER_2 at hold_cnt=2, restart, press ignored in GAME
        tick();
        press();
        points_p2 = 4'd3;
        tick();
        check("p2_win_screen", 32'(screen), 32'(PLAYER_2));
        check("p2_win_tally", 32'(wins_p2), 1);
        points_p2 = 4'd0;
        tick();
        tick();
        check("p2_hold2", 32'(dut.hold_cnt_q), 2);
        press();
        check("skip2_screen", 32'(screen), 32'(START));
        check("skip2_hold", 32'(dut.hold_cnt_q), 0);
        tick();
        press();
        check("restart_screen", 32'(screen), 32'(GAME));
        check("restart_clr", 32'(game_clr), 1);
        tick();
        press();
        check("game_press_screen", 32'(screen), 32'(GAME));
        check("game_press_clr", 32'(game_clr), 0);
        tick();

        // 5: player 2 tally saturates at 15
        exp_p2 = 1;
        for (int r = 0; r < 15; r++) begin
            press();
            points_p2 = 4'd3;
            tick();
            points_p2 = 4'd0;
            exp_p2 = (exp_p2 < 15) ? exp_p2 + 1 : 15;
            check("sat_screen", 32'(screen), 32'(PLAYER_2));
            check("sat_tally", 32'(wins_p2), exp_p2);
            press();
            tick();
        end
        check("sat_final", 32'(wins_p2), 15);
        check("sat_p1", 32'(wins_p1), 2);

        // 6: reset during hold wipes everything
        press();
        points_p1 = 4'd3;
        tick();
        points_p1 = 4'd0;
        check("pre_rst_screen", 32'(screen), 32'(PLAYER_1));
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_hold", 32'(dut.hold_cnt_q), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_screen", 32'(screen), 32'(START));
        check("mid_rst_hold", 32'(dut.hold_cnt_q), 0);
        check("mid_rst_w1", 32'(wins_p1), 0);
        check("mid_rst_w2", 32'(wins_p2), 0);
        check("mid_rst_clr", 32'(game_clr), 0);
        check("mid_rst_ingame", 32'(in_game), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
